// File: rtl/cmd_script_player_if.sv
// RemoteComm-side handshake between the script player (master) and a RemoteComm instance (slave).
interface cmd_script_player_if;
  logic        send_cmd;
  logic [15:0] cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output send_cmd, cmd, input cmd_sent, resp_rdy, resp);
  modport slave  (input send_cmd, cmd, output cmd_sent, resp_rdy, resp);
endinterface

// File: rtl/cmd_script_player.sv
// Plays a FIFO of {cmd, expected resp, settle delay} entries to RemoteComm, checking each
// response with a timeout and tracking pass/error status for the run.
module cmd_script_player #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TMO_W       = 24,
  parameter int unsigned DLY_W       = 20,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic [7:0]               wr_resp,
  input  logic [DLY_W-1:0]         wr_dly,
  output logic                     full,
  output logic                     empty,
  input  logic                     start,
  input  logic                     abort,
  cmd_script_player_if.master      rc,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   fail_idx,
  output logic                     tmo
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 16 + 8 + DLY_W;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_RESP, SETTLE, FINISH} state_t;

  logic [EW-1:0]    mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    run_idx_q, run_idx_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       exp_q, exp_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             send_q, send_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [PW-1:0]    fail_idx_q, fail_idx_d;

  logic             fifo_empty_c, fifo_full_c, push_c, err_c, err_tmo_c;
  logic [EW-1:0]    head_c;

  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign push_c       = wr_en && !fifo_full_c && !abort;
  assign head_c       = mem_q[rd_ptr_q[AW-1:0]];

  // Entry storage; contents need no reset since pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= {wr_cmd, wr_resp, wr_dly};
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    run_idx_d  = run_idx_q;
    tmo_cnt_d  = tmo_cnt_q;
    dly_d      = dly_q;
    exp_d      = exp_q;
    cmd_d      = cmd_q;
    send_d     = 1'b0;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    err_c      = 1'b0;
    err_tmo_c  = 1'b0;

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pass_d     = 1'b0;
          tmo_d      = 1'b0;
          err_cnt_d  = 8'd0;
          fail_idx_d = '0;
          run_idx_d  = '0;
          state_d    = fifo_empty_c ? FINISH : SEND;
        end
      end
      SEND: begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        cmd_d    = head_c[EW-1 -: 16];
        exp_d    = head_c[DLY_W +: 8];
        dly_d    = head_c[DLY_W-1:0];
        send_d   = 1'b1;
        state_d  = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (rc.cmd_sent) begin
          tmo_cnt_d = '0;
          state_d   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response landing on the final count still counts as a response.
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (rc.resp_rdy) begin
          if (rc.resp == exp_q) state_d = SETTLE;
          else                  err_c   = 1'b1;
        end else if (tmo_cnt_d == TMO_MAX) begin
          err_c     = 1'b1;
          err_tmo_c = 1'b1;
        end
      end
      SETTLE: begin
        if (dly_q == '0) begin
          run_idx_d = run_idx_q + PW'(1);
          state_d   = fifo_empty_c ? FINISH : SEND;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (err_c && !abort) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (err_cnt_q == 8'd0) begin
        fail_idx_d = run_idx_q;
        tmo_d      = err_tmo_c;
      end
      state_d = STOP_ON_ERR ? FINISH : SETTLE;
    end

    // Abort overrides everything: flush, suppress the send, end the run.
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      send_d   = 1'b0;
      if (state_q != IDLE && state_q != FINISH) state_d = FINISH;
    end

    if (state_d == FINISH && state_q != FINISH) pass_d = (err_cnt_d == 8'd0) && !abort;
    if (abort && state_q != IDLE) pass_d = 1'b0;

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      run_idx_q  <= '0;
      tmo_cnt_q  <= '0;
      dly_q      <= '0;
      exp_q      <= 8'd0;
      cmd_q      <= 16'h0000;
      send_q     <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      run_idx_q  <= run_idx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      dly_q      <= dly_d;
      exp_q      <= exp_d;
      cmd_q      <= cmd_d;
      send_q     <= send_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign rc.send_cmd = send_q;
  assign rc.cmd      = cmd_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign tmo         = tmo_q;
  assign err_cnt     = err_cnt_q;
  assign fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_cmd_script_player.sv
// Bench for cmd_script_player: instance 0 halts on error, instance 1 continues; a cycle-stepped
// RemoteComm model answers each send and a scoreboard checks the commands issued.
module tb_cmd_script_player;

  logic clk, rst_n;
  logic [1:0]       wr_en, start, abort;
  logic [1:0][15:0] wr_cmd;
  logic [1:0][7:0]  wr_resp;
  logic [1:0][19:0] wr_dly;
  logic [1:0]       full_o, empty_o, busy_o, done_o, pass_o, tmo_o, send_o;
  logic [1:0][7:0]  err_o;
  logic [1:0][3:0]  fidx_o;
  logic [1:0][15:0] cmd_o;
  logic [1:0]       cmd_sent_r, resp_rdy_r;
  logic [1:0][7:0]  resp_r;

  cmd_script_player_if rc0 ();
  cmd_script_player_if rc1 ();

  assign send_o[0] = rc0.send_cmd;   assign send_o[1] = rc1.send_cmd;
  assign cmd_o[0]  = rc0.cmd;        assign cmd_o[1]  = rc1.cmd;
  assign rc0.cmd_sent = cmd_sent_r[0]; assign rc1.cmd_sent = cmd_sent_r[1];
  assign rc0.resp_rdy = resp_rdy_r[0]; assign rc1.resp_rdy = resp_rdy_r[1];
  assign rc0.resp     = resp_r[0];     assign rc1.resp     = resp_r[1];

  cmd_script_player #(.DEPTH(8), .TMO_W(8), .DLY_W(20), .STOP_ON_ERR(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_cmd(wr_cmd[0]), .wr_resp(wr_resp[0]),
    .wr_dly(wr_dly[0]), .full(full_o[0]), .empty(empty_o[0]), .start(start[0]), .abort(abort[0]),
    .rc(rc0), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_cnt(err_o[0]),
    .fail_idx(fidx_o[0]), .tmo(tmo_o[0]));

  cmd_script_player #(.DEPTH(8), .TMO_W(8), .DLY_W(20), .STOP_ON_ERR(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_cmd(wr_cmd[1]), .wr_resp(wr_resp[1]),
    .wr_dly(wr_dly[1]), .full(full_o[1]), .empty(empty_o[1]), .start(start[1]), .abort(abort[1]),
    .rc(rc1), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_cnt(err_o[1]),
    .fail_idx(fidx_o[1]), .tmo(tmo_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [15:0] cmd; logic [7:0] reply; bit silent; } sb_t;
  typedef struct {
    int inst; logic [15:0] cmd; logic [7:0] exp; logic [7:0] reply; bit silent; logic [19:0] dly;
    bit e_pass; logic [7:0] e_err; bit e_tmo; logic [3:0] e_fidx;
  } vec_t;

  sb_t  sb_q0[$], sb_q1[$];
  int   n_tests, n_fail, cyc;
  int   model_phase[2], model_cnt[2];
  sb_t  model_cur[2];
  int   n_sends[2], n_done[2], last_send_cyc[2], last_sent_cyc[2], last_resp_cyc[2], last_done_cyc[2];
  vec_t vec[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void sb_push(input int i, input sb_t e);
    if (i == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
  endfunction

  function automatic void model_clear(input int i);
    if (i == 0) sb_q0.delete(); else sb_q1.delete();
    model_phase[i] = 0;
  endfunction

  // One clock: clear pulses, step the RemoteComm model, match sends against the scoreboard.
  task automatic tick();
    sb_t e;
    int  sz;
    @(posedge clk); #1;
    cyc++;
    wr_en = '0; start = '0; abort = '0;
    for (int i = 0; i < 2; i++) begin
      cmd_sent_r[i] = 1'b0;
      resp_rdy_r[i] = 1'b0;
      if (done_o[i]) begin n_done[i]++; last_done_cyc[i] = cyc; end
      if (model_phase[i] == 1) begin
        model_cnt[i]--;
        if (model_cnt[i] == 0) begin
          cmd_sent_r[i] = 1'b1; last_sent_cyc[i] = cyc; model_phase[i] = 2; model_cnt[i] = 4;
        end
      end else if (model_phase[i] == 2) begin
        model_cnt[i]--;
        if (model_cnt[i] == 0) begin
          if (!model_cur[i].silent) begin
            resp_rdy_r[i] = 1'b1; resp_r[i] = model_cur[i].reply; last_resp_cyc[i] = cyc;
          end
          model_phase[i] = 0;
        end
      end
      if (send_o[i]) begin
        n_sends[i]++;
        last_send_cyc[i] = cyc;
        sz = (i == 0) ? sb_q0.size() : sb_q1.size();
        if (sz == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected send_cmd inst%0d: got cmd %h expected no send", i, cmd_o[i]);
        end else begin
          e = (i == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
          chk($sformatf("send_cmd cmd inst%0d", i), 32'(cmd_o[i]), 32'(e.cmd));
          model_cur[i] = e; model_phase[i] = 1; model_cnt[i] = 3;
        end
      end
    end
  endtask

  task automatic push(input int i, input logic [15:0] c, input logic [7:0] ex, input logic [19:0] d,
                      input logic [7:0] rep, input bit sil, input bit track);
    sb_t e;
    wr_en[i] = 1'b1; wr_cmd[i] = c; wr_resp[i] = ex; wr_dly[i] = d;
    if (track) begin e.cmd = c; e.reply = rep; e.silent = sil; sb_push(i, e); end
    tick();
  endtask

  task automatic run(input int i, input int budget, input string name);
    int n0, k;
    n0 = n_done[i];
    start[i] = 1'b1;
    tick();
    k = 0;
    while (n_done[i] == n0 && k < budget) begin tick(); k++; end
    chk({name, " done pulse"}, 32'(n_done[i] != n0), 32'd1);
  endtask

  initial begin
    int i, s0, n0, k;
    rst_n = 1'b0; wr_en = '0; start = '0; abort = '0;
    wr_cmd = '0; wr_resp = '0; wr_dly = '0;
    cmd_sent_r = '0; resp_rdy_r = '0; resp_r = '0;
    n_tests = 0; n_fail = 0; cyc = 0;
    for (int j = 0; j < 2; j++) begin
      model_phase[j] = 0; model_cnt[j] = 0; n_sends[j] = 0; n_done[j] = 0;
      last_send_cyc[j] = 0; last_sent_cyc[j] = 0; last_resp_cyc[j] = 0; last_done_cyc[j] = 0;
    end

    //            inst cmd       exp    reply  sil  dly     pass err   tmo  fidx
    vec[0] = '{0, 16'h2000, 8'hA5, 8'hA5, 1'b0, 20'd0, 1'b1, 8'd0, 1'b0, 4'd0};
    vec[1] = '{0, 16'h4001, 8'hA5, 8'h5A, 1'b0, 20'd0, 1'b0, 8'd1, 1'b0, 4'd0};
    vec[2] = '{0, 16'h2000, 8'hA5, 8'hA5, 1'b1, 20'd0, 1'b0, 8'd1, 1'b1, 4'd0};
    vec[3] = '{1, 16'h2000, 8'h3C, 8'h3C, 1'b0, 20'd5, 1'b1, 8'd0, 1'b0, 4'd0};
    vec[4] = '{1, 16'h6ABC, 8'hA5, 8'h00, 1'b0, 20'd2, 1'b0, 8'd1, 1'b0, 4'd0};
    vec[5] = '{1, 16'h2000, 8'hA5, 8'hA5, 1'b1, 20'd0, 1'b0, 8'd1, 1'b1, 4'd0};

    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("reset flags inst%0d", j),
          32'({full_o[j], empty_o[j], busy_o[j], done_o[j], pass_o[j], tmo_o[j], send_o[j]}), 32'b0100000);
      chk($sformatf("reset err/fidx/cmd inst%0d", j), {err_o[j], fidx_o[j], 4'h0, cmd_o[j]}, 32'h0);
    end
    rst_n = 1'b1;
    tick(); tick();

    // Single-entry scripts
    for (int v = 0; v < 6; v++) begin
      i = vec[v].inst;
      s0 = n_sends[i];
      push(i, vec[v].cmd, vec[v].exp, vec[v].dly, vec[v].reply, vec[v].silent, 1'b1);
      run(i, 400, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d busy with done", v), 32'(busy_o[i]), 32'd1);
      chk($sformatf("vec%0d pass", v), 32'(pass_o[i]), 32'(vec[v].e_pass));
      chk($sformatf("vec%0d err_cnt", v), 32'(err_o[i]), 32'(vec[v].e_err));
      chk($sformatf("vec%0d tmo", v), 32'(tmo_o[i]), 32'(vec[v].e_tmo));
      chk($sformatf("vec%0d fail_idx", v), 32'(fidx_o[i]), 32'(vec[v].e_fidx));
      chk($sformatf("vec%0d sends", v), 32'(n_sends[i] - s0), 32'd1);
      chk($sformatf("vec%0d empty", v), 32'(empty_o[i]), 32'd1);
      tick(); tick();
      chk($sformatf("vec%0d busy after", v), 32'(busy_o[i]), 32'd0);
    end

    // Two entries with settle delays: exact spacing of second send and of done
    s0 = n_sends[0];
    push(0, 16'h2000, 8'hA5, 20'd2000, 8'hA5, 1'b0, 1'b1);
    push(0, 16'h4001, 8'hA5, 20'd1500, 8'hA5, 1'b0, 1'b1);
    start[0] = 1'b1;
    tick();
    k = 0;
    while (n_sends[0] < s0 + 2 && k < 3000) begin tick(); k++; end
    chk("settle second send spacing", 32'(last_send_cyc[0] - last_resp_cyc[0]), 32'd2003);
    n0 = n_done[0];
    k = 0;
    while (n_done[0] == n0 && k < 2500) begin tick(); k++; end
    chk("settle done spacing", 32'(last_done_cyc[0] - last_resp_cyc[0]), 32'd1502);
    chk("settle pass", 32'(pass_o[0]), 32'd1);
    tick(); tick();

    // Timeout lands exactly 255 clocks into WAIT_RESP
    push(0, 16'h2000, 8'hA5, 20'd0, 8'hA5, 1'b1, 1'b1);
    run(0, 400, "timeout");
    chk("timeout latency", 32'(last_done_cyc[0] - last_sent_cyc[0]), 32'd256);
    chk("timeout tmo/err", {tmo_o[0], 23'd0, err_o[0]}, {1'b1, 23'd0, 8'd1});
    tick(); tick();

    // Halt on first mismatch leaves later entries queued; abort in IDLE flushes without done
    s0 = n_sends[0];
    push(0, 16'h2000, 8'hA5, 20'd0, 8'h5A, 1'b0, 1'b1);
    push(0, 16'h4001, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b1);
    push(0, 16'h4002, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b1);
    run(0, 200, "halt");
    chk("halt sends", 32'(n_sends[0] - s0), 32'd1);
    chk("halt pass/tmo/fidx/err", {pass_o[0], tmo_o[0], 2'b0, fidx_o[0], 16'd0, err_o[0]}, 32'h0000_0001);
    chk("halt entries retained", 32'(empty_o[0]), 32'd0);
    n0 = n_done[0];
    abort[0] = 1'b1;
    tick();
    model_clear(0);
    repeat (5) tick();
    chk("idle abort flush", 32'(empty_o[0]), 32'd1);
    chk("idle abort no done", 32'(n_done[0] - n0), 32'd0);

    // Continue-on-error across three entries
    s0 = n_sends[1];
    push(1, 16'h2000, 8'hA5, 20'd1, 8'hA5, 1'b0, 1'b1);
    push(1, 16'h4001, 8'hA5, 20'd0, 8'h77, 1'b0, 1'b1);
    push(1, 16'h4002, 8'h5A, 20'd3, 8'h5A, 1'b0, 1'b1);
    run(1, 300, "cont");
    chk("cont sends", 32'(n_sends[1] - s0), 32'd3);
    chk("cont err_cnt", 32'(err_o[1]), 32'd1);
    chk("cont fail_idx", 32'(fidx_o[1]), 32'd1);
    chk("cont pass/tmo", 32'({pass_o[1], tmo_o[1]}), 32'd0);
    tick(); tick();

    // Fill to full, drop ninth push, abort mid-response
    for (int j = 0; j < 7; j++) push(0, 16'h3000 + 16'(j), 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b1);
    chk("fifo not full at 7", 32'(full_o[0]), 32'd0);
    push(0, 16'h3007, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b1);
    chk("fifo full at 8", 32'(full_o[0]), 32'd1);
    push(0, 16'h3008, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b0);
    chk("fifo full after drop", 32'({full_o[0], empty_o[0]}), 32'b10);
    s0 = n_sends[0];
    start[0] = 1'b1;
    tick();
    k = 0;
    while (model_phase[0] != 2 && k < 50) begin tick(); k++; end
    chk("abort reached cmd_sent", 32'(model_phase[0]), 32'd2);
    tick();
    n0 = n_done[0];
    abort[0] = 1'b1;
    tick();
    model_clear(0);
    repeat (20) tick();
    chk("abort done pulse", 32'(n_done[0] - n0), 32'd1);
    chk("abort pass", 32'(pass_o[0]), 32'd0);
    chk("abort flush", 32'({empty_o[0], full_o[0], busy_o[0]}), 32'b100);
    chk("abort no more sends", 32'(n_sends[0] - s0), 32'd1);

    // Start on empty FIFO finishes at once with no send
    s0 = n_sends[0];
    run(0, 10, "empty start");
    chk("empty start pass", 32'(pass_o[0]), 32'd1);
    chk("empty start sends", 32'(n_sends[0] - s0), 32'd0);
    tick(); tick();

    // start and abort together in IDLE: flush only
    push(1, 16'h2000, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b0);
    n0 = n_done[1]; s0 = n_sends[1];
    start[1] = 1'b1; abort[1] = 1'b1;
    tick();
    repeat (10) tick();
    chk("start+abort no run", 32'({busy_o[1], empty_o[1]}), 32'b01);
    chk("start+abort no done/send", 32'((n_done[1] - n0) + (n_sends[1] - s0)), 32'd0);

    // Reset mid-run returns to reset values
    push(1, 16'h2000, 8'hA5, 20'd0, 8'hA5, 1'b1, 1'b1);
    push(1, 16'h4001, 8'hA5, 20'd0, 8'hA5, 1'b0, 1'b1);
    start[1] = 1'b1;
    tick();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midrun reset flags", 32'({full_o[1], empty_o[1], busy_o[1], done_o[1], pass_o[1], send_o[1]}),
        32'b010000);
    chk("midrun reset cmd/err", {err_o[1], 8'd0, cmd_o[1]}, 32'h0);
    model_clear(0); model_clear(1);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
